fp_mul_pipe: RTL and testbench

FP_MUL_PIPE -- requirements
Module: fp_mul_pipe

---
 rtl/fp_mul_pipe_if.sv | 27 ++
 rtl/fp_mul_pipe.sv | 176 +++++++++++++++++
 tb/tb_fp_mul_pipe.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/fp_mul_pipe_if.sv
// Operand/result handshake bundle for fp_mul_pipe.
// The master drives operands and out_ready; the slave (the multiplier) drives results.
interface fp_mul_pipe_if #(
   parameter int EXP_W  = 5,
   parameter int MANT_W = 10
);
   localparam int W = 1 + EXP_W + MANT_W;

   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic [3:0]   flags;

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, result, flags
   );

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, result, flags
   );
endinterface

// File: rtl/fp_mul_pipe.sv
// Three-stage floating-point multiplier: unpack/classify, mantissa multiply, normalise/round/pack.
// Define FP_MUL_PIPE_RNE_EN for round-to-nearest-even; otherwise truncates and saturates on overflow.
module fp_mul_pipe #(
   parameter int EXP_W  = 5,
   parameter int MANT_W = 10
) (
   input logic          clk,
   input logic          rst_n,
   fp_mul_pipe_if.slave bus
);
   localparam int W    = 1 + EXP_W + MANT_W;
   localparam int SW   = MANT_W + 1;
   localparam int SW1  = SW + 1;
   localparam int P    = 2 * SW;
   localparam int EW   = EXP_W + 2;
   localparam int XW   = EXP_W + 9;
   localparam int BIAS = (1 << (EXP_W - 1)) - 1;
   localparam int EMAX = (1 << EXP_W) - 1;
   localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MANT_W-1){1'b0}}};

   logic         adv;
   logic         out_valid_q;
   logic [W-1:0] result_q;
   logic [3:0]   flags_q;

   assign adv           = !out_valid_q || bus.out_ready;
   assign bus.in_ready  = adv;
   assign bus.out_valid = out_valid_q;
   assign bus.result    = result_q;
   assign bus.flags     = flags_q;

   logic [EXP_W-1:0]     ea, eb, ea_eff, eb_eff;
   logic [MANT_W-1:0]    fa, fb;
   logic [SW-1:0]        ma_in, mb_in;
   logic                 a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan;
   logic                 sign_in, spec_in, inv_in, nan_out;
   logic [W-1:0]         spec_res_in;
   logic signed [EW-1:0] exp_in;

   always_comb begin
      ea      = bus.a[W-2:MANT_W];
      eb      = bus.b[W-2:MANT_W];
      fa      = bus.a[MANT_W-1:0];
      fb      = bus.b[MANT_W-1:0];
      ea_eff  = (ea == '0) ? EXP_W'(1) : ea;
      eb_eff  = (eb == '0) ? EXP_W'(1) : eb;
      ma_in   = {(ea != '0), fa};
      mb_in   = {(eb != '0), fb};
      a_zero  = (ea == '0) && (fa == '0);
      b_zero  = (eb == '0) && (fb == '0);
      a_inf   = (ea == '1) && (fa == '0);
      b_inf   = (eb == '1) && (fb == '0);
      a_nan   = (ea == '1) && (fa != '0);
      b_nan   = (eb == '1) && (fb != '0);
      a_snan  = a_nan && !fa[MANT_W-1];
      b_snan  = b_nan && !fb[MANT_W-1];
      sign_in = bus.a[W-1] ^ bus.b[W-1];
      exp_in  = EW'(ea_eff) + EW'(eb_eff) - EW'(BIAS);
      nan_out = a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf);
      inv_in  = a_snan || b_snan || (a_inf && b_zero) || (a_zero && b_inf);
      spec_in = a_nan || b_nan || a_inf || b_inf || a_zero || b_zero;
      if (nan_out)
         spec_res_in = QNAN;
      else if (a_inf || b_inf)
         spec_res_in = {sign_in, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
      else
         spec_res_in = {sign_in, {(W-1){1'b0}}};
   end

   logic                 v1, v2;
   logic                 sign1, sign2, spec1, spec2, inv1, inv2;
   logic signed [EW-1:0] exp1, exp2;
   logic [SW-1:0]        ma1, mb1;
   logic [P-1:0]         prod2;
   logic [W-1:0]         spec_res1, spec_res2;
   logic [W-1:0]         res_n;
   logic [3:0]           flags_n;

   // Only the beat-valid bits and the visible output are cleared; payload follows its valid bit.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         v1          <= 1'b0;
         v2          <= 1'b0;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         flags_q     <= '0;
      end else if (adv) begin
         v1          <= bus.in_valid;
         v2          <= v1;
         out_valid_q <= v2;
         if (v2) begin
            result_q <= res_n;
            flags_q  <= flags_n;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (adv) begin
         sign1     <= sign_in;
         spec1     <= spec_in;
         inv1      <= inv_in;
         exp1      <= exp_in;
         ma1       <= ma_in;
         mb1       <= mb_in;
         spec_res1 <= spec_res_in;
         sign2     <= sign1;
         spec2     <= spec1;
         inv2      <= inv1;
         exp2      <= exp1;
         prod2     <= P'(ma1) * P'(mb1);
         spec_res2 <= spec_res1;
      end
   end

   logic signed [XW-1:0] e0, lz, e_norm, e_fin, rsh;
   logic [2*P-1:0]       wide;
   logic [SW-1:0]        kept;
   logic [SW1-1:0]       sum;
   logic [MANT_W-1:0]    frac;
   logic                 guard, rnd, sticky, inc, tiny, inexact, ovf;
   logic [W-1:0]         ovf_res;

   // wide holds the significand aligned so its top SW bits are kept; everything below feeds guard/round/sticky.
   always_comb begin
      lz = XW'(P);
      for (int i = 0; i < P; i++)
         if (prod2[i]) lz = XW'(P - 1 - i);
      e0     = XW'(exp2) + XW'(1);
      rsh    = '0;
      tiny   = 1'b0;
      e_norm = e0 - lz;
      wide   = {prod2 << lz, {P{1'b0}}};
      if (e0 - lz < XW'(1)) begin
         tiny   = 1'b1;
         e_norm = XW'(1);
         if (e0 >= XW'(1)) begin
            wide = {prod2 << (e0 - XW'(1)), {P{1'b0}}};
         end else begin
            rsh  = (XW'(1) - e0 > XW'(MANT_W + 3)) ? XW'(MANT_W + 3) : XW'(1) - e0;
            wide = {prod2, {P{1'b0}}} >> rsh;
         end
      end
      kept    = wide[2*P-1 -: SW];
      guard   = wide[2*P-1-SW];
      rnd     = wide[2*P-2-SW];
      sticky  = |wide[2*P-3-SW:0];
      inexact = guard || rnd || sticky;
`ifdef FP_MUL_PIPE_RNE_EN
      inc     = guard && (rnd || sticky || kept[0]);
      ovf_res = {sign2, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
`else
      inc     = 1'b0;
      ovf_res = {sign2, {(EXP_W-1){1'b1}}, 1'b0, {MANT_W{1'b1}}};
`endif
      sum = {1'b0, kept} + SW1'(inc);
      if (sum[SW])
         e_fin = e_norm + XW'(1);
      else if (sum[SW-1])
         e_fin = e_norm;
      else
         e_fin = '0;
      frac = sum[SW] ? '0 : sum[MANT_W-1:0];
      ovf  = (e_fin >= XW'(EMAX));
      if (spec2) begin
         res_n   = spec_res2;
         flags_n = {inv2, 3'b000};
      end else if (ovf) begin
         res_n   = ovf_res;
         flags_n = 4'b0101;
      end else begin
         res_n   = {sign2, e_fin[EXP_W-1:0], frac};
         flags_n = {2'b00, tiny && inexact, inexact};
      end
   end
endmodule

// File: tb/tb_fp_mul_pipe.sv
// Directed self-checking bench for fp_mul_pipe at half precision, using a result scoreboard.
// Expectations switch with FP_MUL_PIPE_RNE_EN to match the configured rounding mode.
module tb_fp_mul_pipe;
   typedef struct packed {
      logic [15:0] res;
      logic [3:0]  fl;
   } exp_t;

`ifdef FP_MUL_PIPE_RNE_EN
   localparam logic [15:0] OVF_RES    = 16'h7C00;
   localparam logic [15:0] SUB_RES    = 16'h0002;
   localparam logic [15:0] CARRY_RES  = 16'h0400;
   localparam logic [15:0] BINADE_RES = 16'h4000;
`else
   localparam logic [15:0] OVF_RES    = 16'h7BFF;
   localparam logic [15:0] SUB_RES    = 16'h0001;
   localparam logic [15:0] CARRY_RES  = 16'h03FF;
   localparam logic [15:0] BINADE_RES = 16'h3FFF;
`endif

   logic clk;
   logic rst_n;
   exp_t sb[$];
   int   n_assert = 0;
   int   n_fail   = 0;
   int   n_out    = 0;

   fp_mul_pipe_if #(.EXP_W(5), .MANT_W(10)) bus ();

   fp_mul_pipe #(.EXP_W(5), .MANT_W(10)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Called at a sample point where the current output beat is about to be taken.
   task automatic checkOutput();
      exp_t e;
      checkEq($sformatf("out%0d_expected", n_out), 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
         e = sb.pop_front();
         checkEq($sformatf("out%0d_result", n_out), 32'(bus.result), 32'(e.res));
         checkEq($sformatf("out%0d_flags", n_out), 32'(bus.flags), 32'(e.fl));
      end
      n_out++;
   endtask

   // One clock: score any output transfer, then move to the next falling edge.
   task automatic step();
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) checkOutput();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic applyStimulus(input logic [15:0] a_op, input logic [15:0] b_op,
                                input logic [15:0] exp_res, input logic [3:0] exp_fl);
      int guard_cnt = 0;
      bus.in_valid = 1'b1;
      bus.a        = a_op;
      bus.b        = b_op;
      while (bus.in_ready !== 1'b1 && guard_cnt < 50) begin
         step();
         guard_cnt++;
      end
      if (bus.in_ready !== 1'b1) begin
         checkEq("accept_timeout", 32'(bus.in_ready), 32'd1);
      end else begin
         sb.push_back('{res: exp_res, fl: exp_fl});
         step();
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      int guard_cnt = 0;
      while (sb.size() != 0 && guard_cnt < 40) begin
         step();
         guard_cnt++;
      end
      checkEq("drain_empty", 32'(sb.size()), 32'd0);
   endtask

   initial begin
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.out_ready = 1'b0;
      @(negedge clk);
      step();
      step();
      checkEq("rst_out_valid", 32'(bus.out_valid), 32'd0);
      checkEq("rst_result", 32'(bus.result), 32'd0);
      checkEq("rst_flags", 32'(bus.flags), 32'd0);
      checkEq("rst_in_ready", 32'(bus.in_ready), 32'd1);

      rst_n         = 1'b1;
      bus.out_ready = 1'b1;
      step();

      // Latency: result visible after the third rising edge counting the accept edge.
      applyStimulus(16'h3C00, 16'h3C00, 16'h3C00, 4'h0);
      checkEq("lat_edge1", 32'(bus.out_valid), 32'd0);
      step();
      checkEq("lat_edge2", 32'(bus.out_valid), 32'd0);
      step();
      checkEq("lat_edge3", 32'(bus.out_valid), 32'd1);
      drain();

      $display("[TB] back-to-back directed operands");
      applyStimulus(16'h4000, 16'h4200, 16'h4600, 4'h0);
      applyStimulus(16'h7C00, 16'h0000, 16'h7E00, 4'h8);
      applyStimulus(16'h7BFF, 16'h7BFF, OVF_RES, 4'h5);
      applyStimulus(16'h0003, 16'h3800, SUB_RES, 4'h3);
      applyStimulus(16'h7C00, 16'h4000, 16'h7C00, 4'h0);
      applyStimulus(16'hFC00, 16'h4000, 16'hFC00, 4'h0);
      applyStimulus(16'h8000, 16'h3C00, 16'h8000, 4'h0);
      applyStimulus(16'h7D00, 16'h3C00, 16'h7E00, 4'h8);
      applyStimulus(16'h7E01, 16'h3C00, 16'h7E00, 4'h0);
      applyStimulus(16'h7C00, 16'h7E00, 16'h7E00, 4'h0);
      applyStimulus(16'h0400, 16'h3800, 16'h0200, 4'h0);
      applyStimulus(16'h03FF, 16'h3C01, CARRY_RES, 4'h3);
      applyStimulus(16'h3DA8, 16'h3DA8, BINADE_RES, 4'h1);
      applyStimulus(16'hC000, 16'h4200, 16'hC600, 4'h0);
      applyStimulus(16'h0001, 16'h0001, 16'h0000, 4'h3);
      drain();

      $display("[TB] backpressure with out_ready low");
      bus.out_ready = 1'b0;
      applyStimulus(16'h3C00, 16'h4000, 16'h4000, 4'h0);
      applyStimulus(16'h4000, 16'h4000, 16'h4400, 4'h0);
      applyStimulus(16'h4200, 16'h4000, 16'h4600, 4'h0);
      for (int i = 0; i < 3; i++) begin
         checkEq("stall_in_ready", 32'(bus.in_ready), 32'd0);
         checkEq("stall_out_valid", 32'(bus.out_valid), 32'd1);
         checkEq("stall_result", 32'(bus.result), 32'h4000);
         step();
      end
      bus.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         checkEq("stream_valid", 32'(bus.out_valid), 32'd1);
         step();
      end
      checkEq("stream_gap", 32'(bus.out_valid), 32'd0);
      checkEq("stream_sb_empty", 32'(sb.size()), 32'd0);

      $display("[TB] reset with beats in flight");
      bus.out_ready = 1'b0;
      applyStimulus(16'h4000, 16'h4200, 16'h4600, 4'h0);
      applyStimulus(16'h3C00, 16'h3C00, 16'h3C00, 4'h0);
      applyStimulus(16'h4000, 16'h4000, 16'h4400, 4'h0);
      sb.delete();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      checkEq("rst2_out_valid", 32'(bus.out_valid), 32'd0);
      checkEq("rst2_in_ready", 32'(bus.in_ready), 32'd1);
      checkEq("rst2_result", 32'(bus.result), 32'd0);
      checkEq("rst2_flags", 32'(bus.flags), 32'd0);
      bus.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         checkEq("rst2_no_stale", 32'(bus.out_valid), 32'd0);
      end
      applyStimulus(16'hC000, 16'h4200, 16'hC600, 4'h0);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] simulation did not finish in time");
   end
endmodule
